perf_monitor: RTL and testbench

Parametrised, synthesisable performance monitor for the pipelined `cpu`. It counts per-cycle event pulses (retire, I/D-cache request/hit, and so on) in saturating counters, alongside a free-running cycle counter. Counting freezes on `hlt` and a cycle watchdog can trip. Results are exposed through a registered read port so that on-chip debug logic and benches read the same statistics.

---
 rtl/perf_pkg.sv | 23 ++
 rtl/perf_sat_counter.sv | 41 ++++
 rtl/perf_monitor.sv | 126 ++++++++++++
 tb/tb_perf_monitor.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/perf_pkg.sv
// Shared types and constants for the CPU performance monitor.
package perf_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_RUN     = 2'd1,
        ST_HALTED  = 2'd2,
        ST_TRIPPED = 2'd3
    } perf_state_t;

    localparam int unsigned EV_RETIRE = 0;
    localparam int unsigned EV_IC_REQ = 1;
    localparam int unsigned EV_IC_HIT = 2;
    localparam int unsigned EV_DC_REQ = 3;
    localparam int unsigned EV_DC_HIT = 4;
    localparam int unsigned EV_MEM_WR = 5;

    // Read select must also reach the extra cycle-counter slot.
    function automatic int unsigned sel_w(input int unsigned num_events);
        return $clog2(num_events + 1);
    endfunction

endpackage

// File: rtl/perf_sat_counter.sv
// Saturating up-counter with a sticky flag set by an increment attempted at all-ones.
module perf_sat_counter #(
    parameter int unsigned W = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] count,
    output logic         sat
);

    logic [W-1:0] count_q, count_d;
    logic         sat_q, sat_d;

    always_comb begin
        count_d = count_q;
        sat_d   = sat_q;
        if (clr) begin
            count_d = '0;
            sat_d   = 1'b0;
        end else if (inc) begin
            if (&count_q) sat_d   = 1'b1;
            else          count_d = count_q + W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
            sat_q   <= 1'b0;
        end else begin
            count_q <= count_d;
            sat_q   <= sat_d;
        end
    end

    assign count = count_q;
    assign sat   = sat_q;

endmodule

// File: rtl/perf_monitor.sv
// Performance monitor: event/cycle counters gated by a run FSM, a cycle watchdog
// and a registered read port shared by debug logic and benches.
module perf_monitor #(
    parameter int unsigned NUM_EVENTS = 6,
    parameter int unsigned CNT_W      = 32,
    parameter int unsigned CYC_W      = 32,
    parameter int unsigned WDOG_LIMIT = 100000
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               enable,
    input  logic                               clear,
    input  logic [NUM_EVENTS-1:0]              events,
    input  logic                               hlt,
    input  logic [$clog2(NUM_EVENTS+1)-1:0]    rd_sel,
    output logic [CNT_W-1:0]                   rd_data,
    output logic                               rd_sat,
    output logic [CYC_W-1:0]                   cycle_count,
    output logic [1:0]                         state_o,
    output logic                               wdog_trip
);
    import perf_pkg::*;

    localparam int unsigned SEL_W = sel_w(NUM_EVENTS);
    localparam int unsigned CMP_W = CYC_W + 1;

    perf_state_t            state_q, state_d;
    logic                   wdog_q, wdog_d;
    logic [CNT_W-1:0]       rd_data_q, rd_data_d;
    logic                   rd_sat_q, rd_sat_d;

    logic [CNT_W-1:0]       ev_cnt [NUM_EVENTS];
    logic [NUM_EVENTS-1:0]  ev_sat;
    logic [CYC_W-1:0]       cyc_cnt;
    logic                   cyc_sat;
    logic [CYC_W-1:0]       cyc_next;
    logic                   counting;
    logic                   wdog_hit;

    assign counting = (state_q == ST_RUN) && enable && !clear;

    // Compare one bit wider so a limit beyond the counter range never matches.
    assign cyc_next = (&cyc_cnt) ? cyc_cnt : cyc_cnt + CYC_W'(1);
    assign wdog_hit = (WDOG_LIMIT != 0) && ({1'b0, cyc_next} == CMP_W'(WDOG_LIMIT));

    for (genvar i = 0; i < NUM_EVENTS; i++) begin : g_ev
        perf_sat_counter #(.W(CNT_W)) u_ev_cnt (
            .clk   (clk),
            .rst   (rst),
            .clr   (clear),
            .inc   (counting && events[i]),
            .count (ev_cnt[i]),
            .sat   (ev_sat[i])
        );
    end

    perf_sat_counter #(.W(CYC_W)) u_cyc_cnt (
        .clk   (clk),
        .rst   (rst),
        .clr   (clear),
        .inc   (counting),
        .count (cyc_cnt),
        .sat   (cyc_sat)
    );

    // Halt wins over the watchdog; clear wins over everything.
    always_comb begin
        state_d = state_q;
        wdog_d  = wdog_q;
        if (clear) begin
            state_d = ST_IDLE;
            wdog_d  = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: if (enable) state_d = ST_RUN;
                ST_RUN: begin
                    if (hlt) begin
                        state_d = ST_HALTED;
                    end else if (counting && wdog_hit) begin
                        state_d = ST_TRIPPED;
                        wdog_d  = 1'b1;
                    end
                end
                default: state_d = state_q;
            endcase
        end
    end

    always_comb begin
        rd_data_d = '0;
        rd_sat_d  = 1'b0;
        if (!clear) begin
            for (int i = 0; i < NUM_EVENTS; i++) begin
                if (rd_sel == SEL_W'(i)) begin
                    rd_data_d = ev_cnt[i];
                    rd_sat_d  = ev_sat[i];
                end
            end
            if (rd_sel == SEL_W'(NUM_EVENTS)) begin
                rd_data_d = CNT_W'(cyc_cnt);
                rd_sat_d  = cyc_sat;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            wdog_q    <= 1'b0;
            rd_data_q <= '0;
            rd_sat_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            wdog_q    <= wdog_d;
            rd_data_q <= rd_data_d;
            rd_sat_q  <= rd_sat_d;
        end
    end

    assign rd_data     = rd_data_q;
    assign rd_sat      = rd_sat_q;
    assign cycle_count = cyc_cnt;
    assign state_o     = state_q;
    assign wdog_trip   = wdog_q;

endmodule

// File: tb/tb_perf_monitor.sv
// Randomised and directed bench for perf_monitor against an integer reference model.
module tb_perf_monitor;

    localparam int unsigned NE    = 6;
    localparam int unsigned CW    = 4;
    localparam int unsigned YW    = 8;
    localparam int unsigned LIMIT = 50;
    localparam int CNT_MAX = (1 << CW) - 1;
    localparam int CYC_MAX = (1 << YW) - 1;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          enable = 1'b0;
    logic          clear = 1'b0;
    logic [NE-1:0] events = '0;
    logic          hlt = 1'b0;
    logic [2:0]    rd_sel = '0;
    logic [CW-1:0] rd_data;
    logic          rd_sat;
    logic [YW-1:0] cycle_count;
    logic [1:0]    state_o;
    logic          wdog_trip;

    int errors = 0;
    int checks = 0;

    // Reference model state: plain integers, mode uses the published state numbers.
    int m_cnt [NE];
    bit m_sat [NE];
    int m_cyc;
    bit m_cyc_sat;
    int m_mode;
    bit m_trip;
    int m_rd;
    bit m_rsat;

    perf_monitor #(
        .NUM_EVENTS (NE),
        .CNT_W      (CW),
        .CYC_W      (YW),
        .WDOG_LIMIT (LIMIT)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .enable      (enable),
        .clear       (clear),
        .events      (events),
        .hlt         (hlt),
        .rd_sel      (rd_sel),
        .rd_data     (rd_data),
        .rd_sat      (rd_sat),
        .cycle_count (cycle_count),
        .state_o     (state_o),
        .wdog_trip   (wdog_trip)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic model_update(input bit rs, input bit en, input bit cl,
                                input logic [NE-1:0] ev, input bit h, input int sel);
        bit counted;
        if (rs || cl) begin
            for (int i = 0; i < NE; i++) begin
                m_cnt[i] = 0;
                m_sat[i] = 0;
            end
            m_cyc = 0; m_cyc_sat = 0; m_mode = 0; m_trip = 0; m_rd = 0; m_rsat = 0;
            return;
        end
        // Read sees values from before this edge's increments.
        if (sel < NE) begin
            m_rd = m_cnt[sel]; m_rsat = m_sat[sel];
        end else if (sel == NE) begin
            m_rd = m_cyc % (CNT_MAX + 1); m_rsat = m_cyc_sat;
        end else begin
            m_rd = 0; m_rsat = 0;
        end
        counted = (m_mode == 1) && en;
        if (counted) begin
            if (m_cyc == CYC_MAX) m_cyc_sat = 1; else m_cyc = m_cyc + 1;
            for (int i = 0; i < NE; i++)
                if (ev[i]) begin
                    if (m_cnt[i] == CNT_MAX) m_sat[i] = 1; else m_cnt[i] = m_cnt[i] + 1;
                end
        end
        if (m_mode == 0) begin
            if (en) m_mode = 1;
        end else if (m_mode == 1) begin
            if (h) m_mode = 2;
            else if (counted && m_cyc == LIMIT) begin
                m_mode = 3; m_trip = 1;
            end
        end
    endtask

    task automatic step(input bit rs, input bit en, input bit cl,
                        input logic [NE-1:0] ev, input bit h, input logic [2:0] sel);
        rst = rs; enable = en; clear = cl; events = ev; hlt = h; rd_sel = sel;
        @(posedge clk);
        model_update(rs, en, cl, ev, h, int'(sel));
        #1;
        check("rd_data", int'(rd_data), m_rd);
        check("rd_sat", int'(rd_sat), int'(m_rsat));
        check("cycle_count", int'(cycle_count), m_cyc);
        check("state", int'(state_o), m_mode);
        check("wdog_trip", int'(wdog_trip), int'(m_trip));
    endtask

    task automatic run(input bit en, input logic [NE-1:0] ev, input bit h, input logic [2:0] sel);
        step(1'b0, en, 1'b0, ev, h, sel);
    endtask

    task automatic restart();
        step(1'b0, 1'b0, 1'b1, '0, 1'b0, 3'd0);
        run(1'b1, '0, 1'b0, 3'd0);
    endtask

    initial begin
        // Reset state
        step(1'b1, 1'b0, 1'b0, '0, 1'b0, 3'd0);
        step(1'b1, 1'b1, 1'b0, 6'h3f, 1'b0, 3'd6);
        check("rst_state", int'(state_o), 0);
        check("rst_rd", int'(rd_data), 0);

        // Ten counted cycles of retire + icache-request
        run(1'b1, 6'b000011, 1'b0, 3'd0);
        for (int i = 0; i < 10; i++) run(1'b1, 6'b000011, 1'b0, 3'd0);
        run(1'b0, '0, 1'b0, 3'd0);
        check("p1_cnt0", int'(rd_data), 10);
        run(1'b0, '0, 1'b0, 3'd1);
        check("p1_cnt1", int'(rd_data), 10);
        run(1'b0, '0, 1'b0, 3'd2);
        check("p1_cnt2", int'(rd_data), 0);
        check("p1_cycles", int'(cycle_count), 10);
        check("p1_state", int'(state_o), 1);

        // Halt on the 7th counted cycle freezes counting
        restart();
        for (int i = 1; i <= 7; i++) run(1'b1, 6'b001000, (i == 7), 3'd3);
        for (int i = 0; i < 20; i++) run(1'b1, 6'b001000, 1'b0, 3'($urandom_range(0, 7)));
        run(1'b1, 6'b001000, 1'b0, 3'd3);
        check("halt_cnt3", int'(rd_data), 7);
        check("halt_cycles", int'(cycle_count), 7);
        check("halt_state", int'(state_o), 2);

        // 4-bit counter saturation
        restart();
        for (int i = 0; i < 20; i++) run(1'b1, 6'b000001, 1'b0, 3'd0);
        run(1'b0, '0, 1'b0, 3'd0);
        check("sat_cnt0", int'(rd_data), 15);
        check("sat_flag", int'(rd_sat), 1);
        check("sat_cycles", int'(cycle_count), 20);

        // Watchdog trips at 50 counted cycles
        restart();
        for (int i = 0; i < 55; i++) run(1'b1, 6'($urandom), 1'b0, 3'($urandom_range(0, 7)));
        check("wd_trip", int'(wdog_trip), 1);
        check("wd_cycles", int'(cycle_count), 50);
        check("wd_state", int'(state_o), 3);

        // Halt coinciding with the watchdog compare wins
        restart();
        for (int i = 1; i <= 50; i++) run(1'b1, '0, (i == 50), 3'd6);
        for (int i = 0; i < 3; i++) run(1'b1, '0, 1'b0, 3'd6);
        check("wdh_state", int'(state_o), 2);
        check("wdh_trip", int'(wdog_trip), 0);
        check("wdh_cycles", int'(cycle_count), 50);

        // Clear together with halt mid-run, then restart from zero
        restart();
        for (int i = 0; i < 5; i++) run(1'b1, 6'h3f, 1'b0, 3'd0);
        step(1'b0, 1'b1, 1'b1, 6'h3f, 1'b1, 3'd0);
        check("clr_state", int'(state_o), 0);
        check("clr_cycles", int'(cycle_count), 0);
        run(1'b1, 6'b000001, 1'b0, 3'd0);
        for (int i = 0; i < 3; i++) run(1'b1, 6'b000001, 1'b0, 3'd0);
        run(1'b0, '0, 1'b0, 3'd0);
        check("clr_recount", int'(rd_data), 3);
        check("clr_recycles", int'(cycle_count), 3);

        // Read-select sweep including the cycle slot and an out-of-range select
        for (int s = 0; s < 8; s++) run(1'b1, 6'($urandom), 1'b0, 3'(s));
        check("sweep_sel7", int'(rd_data), 0);

        // Randomised traffic
        for (int i = 0; i < 600; i++) begin
            step(($urandom_range(0, 63) == 0),
                 ($urandom_range(0, 3) != 0),
                 ($urandom_range(0, 15) == 0),
                 6'($urandom),
                 ($urandom_range(0, 31) == 0),
                 3'($urandom_range(0, 7)));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
